// File: rtl/jk_bank_pkg.sv
// jk_bank_pkg: shared state encoding and JK excitation codes for the bank driver
package jk_bank_pkg;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_DRIVE, S_SAMPLE, S_DONE, S_ERR} state_t;
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_RST  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;
  function automatic logic [1:0] jk_excite(input logic q, input logic t, input logic mode);
    return (q == t) ? JK_HOLD : mode ? JK_TGL : t ? JK_SET : JK_RST;
  endfunction
endpackage

// File: rtl/jk_excite_bit.sv
// jk_excite_bit: {J,K} code that moves one cell from q to t
module jk_excite_bit
  import jk_bank_pkg::*;
(
  input  logic       q,
  input  logic       t,
  input  logic       mode,
  output logic [1:0] jk
);
  assign jk = jk_excite(q, t, mode);
endmodule

// File: rtl/jk_bank_driver.sv
// jk_bank_driver: drives a JK cell bank to a target word with readback and retry
module jk_bank_driver
  import jk_bank_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int MAX_RETRY = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tgt_valid,
  input  logic [WIDTH-1:0]   tgt_data,
  input  logic               tgt_mode,
  output logic               tgt_ready,
  input  logic               clr_req,
  output logic [2*WIDTH-1:0] jk,
  output logic               ff_rst,
  input  logic [WIDTH-1:0]   q_fb,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [WIDTH-1:0]   err_bits
);
  localparam logic [2:0] MAX_R = 3'(MAX_RETRY);
  state_t               state, state_n;
  logic [WIDTH-1:0]     tgt_q, tgt_n, exc_tgt, err_bits_n;
  logic                 mode_q, mode_n, exc_mode, ff_rst_n, done_n, err_n;
  logic [2:0]           retry, retry_n;
  logic [2*WIDTH-1:0]   jk_n, exc;
  // jk is registered, so excitation is computed for the target being entered
  assign exc_tgt   = (state == S_IDLE) ? tgt_data : tgt_q;
  assign exc_mode  = (state == S_IDLE) ? tgt_mode : mode_q;
  assign tgt_ready = (state == S_IDLE) && !clr_req && !rst;
  for (genvar i = 0; i < WIDTH; i++) begin : g_exc
    jk_excite_bit u_bit (.q(q_fb[i]), .t(exc_tgt[i]), .mode(exc_mode), .jk(exc[2*i +: 2]));
  end
  always_comb begin
    state_n    = state;
    tgt_n      = tgt_q;
    mode_n     = mode_q;
    retry_n    = retry;
    jk_n       = '0;
    ff_rst_n   = 1'b0;
    done_n     = 1'b0;
    err_n      = 1'b0;
    err_bits_n = err_bits;
    case (state)
      S_IDLE:
        if (clr_req) begin
          state_n  = S_CLEAR;
          tgt_n    = '0;
          retry_n  = '0;
          ff_rst_n = 1'b1;
        end else if (tgt_valid) begin
          state_n    = S_DRIVE;
          tgt_n      = tgt_data;
          mode_n     = tgt_mode;
          retry_n    = '0;
          err_bits_n = '0;
          jk_n       = exc;
        end
      S_CLEAR: state_n = S_SAMPLE;
      S_DRIVE: begin
        state_n = S_SAMPLE;
        retry_n = retry + 3'd1;
      end
      S_SAMPLE:
        if (q_fb == tgt_q) begin
          state_n = S_DONE;
          done_n  = 1'b1;
        end else if (retry == MAX_R) begin
          state_n    = S_ERR;
          err_n      = 1'b1;
          err_bits_n = q_fb ^ tgt_q;
        end else begin
          state_n = S_DRIVE;
          jk_n    = exc;
        end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tgt_q    <= '0;
      mode_q   <= 1'b0;
      retry    <= '0;
      jk       <= '0;
      ff_rst   <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      err_bits <= '0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      tgt_q    <= tgt_n;
      mode_q   <= mode_n;
      retry    <= retry_n;
      jk       <= jk_n;
      ff_rst   <= ff_rst_n;
      done     <= done_n;
      err      <= err_n;
      err_bits <= err_bits_n;
      busy     <= state_n != S_IDLE;
    end
  end
endmodule

// File: tb/tb_jk_bank_driver.sv
// tb_jk_bank_driver: directed checks of the driver against a behavioural JK cell bank
module tb_jk_bank_driver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tgt_valid = 1'b0;
  logic [3:0] tgt_data = '0;
  logic       tgt_mode = 1'b0;
  logic       tgt_ready;
  logic       clr_req = 1'b0;
  logic [7:0] jk;
  logic       ff_rst;
  logic [3:0] q_fb;
  logic       busy, done, err;
  logic [3:0] err_bits;
  logic [3:0] bank;
  logic [3:0] stuck0 = '0;
  int errors = 0;
  int checks = 0;

  jk_bank_driver #(.WIDTH(4), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_mode(tgt_mode),
    .tgt_ready(tgt_ready), .clr_req(clr_req), .jk(jk), .ff_rst(ff_rst), .q_fb(q_fb),
    .busy(busy), .done(done), .err(err), .err_bits(err_bits)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      bank[i] <= ff_rst ? 1'b0 :
                 (jk[2*i +: 2] == 2'b01) ? 1'b0 :
                 (jk[2*i +: 2] == 2'b10) ? 1'b1 :
                 (jk[2*i +: 2] == 2'b11) ? ~bank[i] : bank[i];
  end
  assign q_fb = bank & ~stuck0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    step();
    chk("rst_ready", tgt_ready, 0);
    chk("rst_jk", jk, 0);
    chk("rst_ffrst", ff_rst, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done_err", {done, err}, 0);
    chk("rst_errbits", err_bits, 0);
    step();
    rst = 1'b0;
    step();
    chk("idle_ffrst", ff_rst, 0);
    chk("idle_ready", tgt_ready, 1);
    // test 1: bank clear
    clr_req = 1'b1;
    #1 chk("t1_ready_clr", tgt_ready, 0);
    step();
    clr_req = 1'b0;
    chk("t1_clear_ffrst", ff_rst, 1);
    chk("t1_clear_busy", busy, 1);
    chk("t1_clear_done", done, 0);
    step();
    chk("t1_sample_ffrst", ff_rst, 0);
    chk("t1_qfb", q_fb, 4'b0000);
    step();
    chk("t1_done", done, 1);
    step();
    chk("t1_idle", {busy, done, tgt_ready}, 3'b001);
    // test 2: 0000 -> 1010 set/reset
    tgt_valid = 1'b1; tgt_data = 4'b1010; tgt_mode = 1'b0;
    #1 chk("t2_ready", tgt_ready, 1);
    step();
    tgt_valid = 1'b0;
    chk("t2_jk", jk, 8'b10_00_10_00);
    chk("t2_busy_ready", {busy, tgt_ready}, 2'b10);
    step();
    chk("t2_sample_jk", jk, 0);
    chk("t2_qfb", q_fb, 4'b1010);
    step();
    chk("t2_done", {done, err}, 2'b10);
    step();
    chk("t2_idle", {done, tgt_ready}, 2'b01);
    // test 3: 1010 -> 0110 toggle
    tgt_valid = 1'b1; tgt_data = 4'b0110; tgt_mode = 1'b1;
    step();
    tgt_valid = 1'b0;
    chk("t3_jk", jk, 8'b11_11_00_00);
    step();
    chk("t3_qfb", q_fb, 4'b0110);
    step();
    chk("t3_done", done, 1);
    step();
    // clear back to 0000, then test 4: bit 0 stuck low
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    chk("t4_pre_clear_done", done, 1);
    step();
    stuck0 = 4'b0001;
    tgt_valid = 1'b1; tgt_data = 4'b0001; tgt_mode = 1'b0;
    step();
    tgt_valid = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      chk($sformatf("t4_drive%0d_jk", r), jk, 8'b00_00_00_10);
      chk($sformatf("t4_drive%0d_done", r), {done, err}, 0);
      step();
      chk($sformatf("t4_sample%0d_jk", r), jk, 0);
      chk($sformatf("t4_sample%0d_done", r), {done, err}, 0);
      step();
    end
    chk("t4_err", {done, err}, 2'b01);
    chk("t4_errbits", err_bits, 4'b0001);
    step();
    chk("t4_idle", {busy, err, tgt_ready}, 3'b001);
    chk("t4_errbits_held", err_bits, 4'b0001);
    stuck0 = '0;
    // test 5: clr_req wins over tgt_valid
    clr_req = 1'b1; tgt_valid = 1'b1; tgt_data = 4'b0101; tgt_mode = 1'b0;
    #1 chk("t5_ready_blocked", tgt_ready, 0);
    step();
    clr_req = 1'b0;
    chk("t5_clear_ffrst", ff_rst, 1);
    chk("t5_clear_jk", jk, 0);
    step();
    step();
    chk("t5_clear_done", done, 1);
    step();
    chk("t5_ready", tgt_ready, 1);
    step();
    tgt_valid = 1'b0;
    chk("t5_jk", jk, 8'b00_10_00_10);
    chk("t5_errbits_cleared", err_bits, 0);
    step();
    step();
    chk("t5_done", done, 1);
    chk("t5_qfb", q_fb, 4'b0101);
    step();
    // test 6: reset during SAMPLE
    tgt_valid = 1'b1; tgt_data = 4'b1010; tgt_mode = 1'b0;
    step();
    tgt_valid = 1'b0;
    chk("t6_jk", jk, 8'b10_01_10_01);
    step();
    rst = 1'b1;
    step();
    chk("t6_rst_jk", jk, 0);
    chk("t6_rst_ffrst", ff_rst, 1);
    chk("t6_rst_state", {busy, done, err, tgt_ready}, 0);
    rst = 1'b0;
    step();
    chk("t6_idle", {busy, done, err, tgt_ready}, 4'b0001);
    chk("t6_qfb", q_fb, 4'b0000);
    step();
    chk("t6_quiet", {done, err}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
